// File: rtl/guess_game_ctrl.sv
// Round sequencer for the binary guessing game: latches a pseudo-random value,
// blinks it on the LEDs, takes up to MAX_TRIES guesses and reports win or loss.
module guess_game_ctrl #(
  parameter int BLINK_TICKS = 4,
  parameter int SHOW_BLINKS = 3,
  parameter int MAX_TRIES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] guess,
  output logic [3:0] system_val,
  output logic       show_en,
  output logic       hint_high,
  output logic       hint_low,
  output logic [1:0] tries_left,
  output logic       win,
  output logic       lose,
  output logic [2:0] state_dbg
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HW = $clog2(2 * SHOW_BLINKS + 1);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(2 * SHOW_BLINKS);
  localparam logic [1:0]    TRIES_INIT = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHOW  = 3'd1,
    S_GUESS = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      entropy_q, entropy_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [HW-1:0]   half_q, half_d;
  logic [3:0]      val_q, val_d;
  logic            show_q, show_d;
  logic            hh_q, hh_d;
  logic            hl_q, hl_d;
  logic [1:0]      tries_q, tries_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            start_round;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      entropy_q <= 4'd0;
      blink_q   <= '0;
      half_q    <= '0;
      val_q     <= 4'd0;
      show_q    <= 1'b0;
      hh_q      <= 1'b0;
      hl_q      <= 1'b0;
      tries_q   <= 2'd0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      entropy_q <= entropy_d;
      blink_q   <= blink_d;
      half_q    <= half_d;
      val_q     <= val_d;
      show_q    <= show_d;
      hh_q      <= hh_d;
      hl_q      <= hl_d;
      tries_q   <= tries_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  // start and submit are one-cycle pulses with no handshake back; a pulse is
  // acted on only in the states that accept it and is otherwise dropped.
  always_comb begin
    state_d     = state_q;
    entropy_d   = entropy_q + 4'd1;
    blink_d     = blink_q;
    half_d      = half_q;
    val_d       = val_q;
    show_d      = show_q;
    hh_d        = hh_q;
    hl_d        = hl_q;
    tries_d     = tries_q;
    win_d       = win_q;
    lose_d      = lose_q;
    start_round = 1'b0;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        start_round = start;
      end

      S_SHOW: begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          show_d  = ~show_q;
          half_d  = half_q + HW'(1);
          if (half_d == HALF_LAST) begin
            state_d = S_GUESS;
            show_d  = 1'b0;
          end
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end

      S_GUESS: begin
        show_d = 1'b0;
        if (submit) begin
          if (guess == val_q) begin
            state_d = S_WIN;
            win_d   = 1'b1;
            hh_d    = 1'b0;
            hl_d    = 1'b0;
            show_d  = 1'b1;
          end else begin
            hh_d = (guess > val_q);
            hl_d = (guess < val_q);
            if (tries_q > 2'd1) begin
              tries_d = tries_q - 2'd1;
            end else begin
              // Last try spent: reveal the value and stop accepting guesses.
              tries_d = 2'd0;
              state_d = S_LOSE;
              lose_d  = 1'b1;
              show_d  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        show_d  = 1'b0;
        hh_d    = 1'b0;
        hl_d    = 1'b0;
        tries_d = 2'd0;
        win_d   = 1'b0;
        lose_d  = 1'b0;
      end
    endcase

    // The entropy sample is the counter value seen on the start cycle itself.
    if (start_round) begin
      state_d = S_SHOW;
      val_d   = entropy_q;
      tries_d = TRIES_INIT;
      hh_d    = 1'b0;
      hl_d    = 1'b0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      show_d  = 1'b1;
      blink_d = '0;
      half_d  = '0;
    end
  end

  assign system_val = val_q;
  assign show_en    = show_q;
  assign hint_high  = hh_q;
  assign hint_low   = hl_q;
  assign tries_left = tries_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign state_dbg  = state_q;

endmodule
